// File: rtl/neuron_sweep_scheduler.sv
// Per-dt neuron sweep sequencer: walks neuron addresses on dt_tick, fans the issue strobe out
// through staged delay lines, and slots host accesses into idle gaps between sweeps.
module neuron_sweep_scheduler #(
  parameter int NEURON_NO = 256,
  parameter int EFA_LAT   = 3,
  parameter int SRM_LAT   = 4,
  parameter int REF_LAT   = 5,
  localparam int AW       = $clog2(NEURON_NO)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          sys_en,
  input  logic          dt_tick,
  input  logic [1:0]    ext_req,
  input  logic [AW-1:0] ext_addr,
  output logic          t_fix_wr_en,
  output logic [AW-1:0] t_fix_wr_addr,
  output logic          efa_wr_en,
  output logic [AW-1:0] efa_wr_addr,
  output logic          srm_en,
  output logic          ref_wr_en,
  output logic [AW-1:0] ref_wr_addr,
  output logic          sweep_busy,
  output logic          sweep_done,
  output logic          overrun,
  output logic          ext_grant,
  output logic          ext_rd_en,
  output logic          ext_wr_en,
  output logic [AW-1:0] ext_mem_addr
);

  typedef enum logic [1:0] {IDLE, SWEEP, DRAIN, EXT} state_t;

  typedef struct packed {
    logic          grant;
    logic          rd;
    logic          wr;
    logic [AW-1:0] addr;
  } ext_rsp_t;

  state_t                   state, state_d;
  logic [AW-1:0]            cnt;
  logic                     issue, last;
  logic [AW-1:0]            issue_addr;
  ext_rsp_t                 ext_d, ext_q;

  // Stage 0 is the t_fix issue; stage n is n cycles later. The last flag rides along so
  // sweep_done lands exactly on the final ref write, whatever pauses occurred.
  logic [REF_LAT:0]         vld_pipe;
  logic [REF_LAT:0]         last_pipe;
  logic [REF_LAT:0][AW-1:0] addr_pipe;

  always_comb begin
    state_d    = state;
    issue      = 1'b0;
    issue_addr = '0;
    ext_d      = '0;
    case (state)
      IDLE: begin
        if (dt_tick) begin
          if (sys_en) begin
            state_d = SWEEP;
            issue   = 1'b1;
          end
        end else if (ext_req == 2'd1 || ext_req == 2'd2) begin
          state_d     = EXT;
          ext_d.grant = 1'b1;
          ext_d.rd    = (ext_req == 2'd1);
          ext_d.wr    = (ext_req == 2'd2);
          ext_d.addr  = ext_addr;
        end
      end
      SWEEP: begin
        if (sys_en) begin
          issue      = 1'b1;
          issue_addr = cnt;
        end
      end
      DRAIN:   if (last_pipe[REF_LAT]) state_d = IDLE;
      EXT:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
    last = issue && (issue_addr == AW'(NEURON_NO - 1));
    if (last) state_d = DRAIN;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      cnt        <= '0;
      vld_pipe   <= '0;
      last_pipe  <= '0;
      addr_pipe  <= '0;
      ext_q      <= '0;
      sweep_busy <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      state      <= state_d;
      if (issue) cnt <= issue_addr + AW'(1);
      vld_pipe   <= {vld_pipe[REF_LAT-1:0], issue};
      last_pipe  <= {last_pipe[REF_LAT-1:0], last};
      addr_pipe  <= {addr_pipe[REF_LAT-1:0], issue_addr};
      ext_q      <= ext_d;
      sweep_busy <= (state_d == SWEEP) || (state_d == DRAIN);
      if (dt_tick && sweep_busy) overrun <= 1'b1;
    end
  end

  assign t_fix_wr_en   = vld_pipe[0];
  assign t_fix_wr_addr = addr_pipe[0];
  assign efa_wr_en     = vld_pipe[EFA_LAT];
  assign efa_wr_addr   = addr_pipe[EFA_LAT];
  assign srm_en        = vld_pipe[SRM_LAT];
  assign ref_wr_en     = vld_pipe[REF_LAT];
  assign ref_wr_addr   = addr_pipe[REF_LAT];
  assign sweep_done    = last_pipe[REF_LAT];
  assign ext_grant     = ext_q.grant;
  assign ext_rd_en     = ext_q.rd;
  assign ext_wr_en     = ext_q.wr;
  assign ext_mem_addr  = ext_q.addr;

endmodule
